// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: state encoding,
// default geometry and a counter-width helper.
package serial_pattern_tx_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_GAP   = 2;
  localparam int DEF_REP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } tx_state_t;

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Handshake and serial-output bundle between a pattern source and the
// transmitter; master drives requests, slave drives the serial stream.
interface serial_pattern_tx_if
  import serial_pattern_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REP_W = DEF_REP_W
);

  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [REP_W-1:0] rep_cnt;
  logic             abort;
  logic             ready;
  logic             w;
  logic             w_valid;
  logic             done;

  modport master (
    output start, pattern, rep_cnt, abort,
    input  ready, w, w_valid, done
  );

  modport slave (
    input  start, pattern, rep_cnt, abort,
    output ready, w, w_valid, done
  );

endinterface

// File: rtl/serial_pattern_tx_piso_shift_reg.sv
// Parallel-in serial-out shift register; load has priority over shift and
// the MSB is the bit currently presented.
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] shreg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift_en) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = shreg[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: accepts a pattern and repeat count, shifts it
// out MSB-first with an idle gap between repeats, then pulses done.
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GAP   = DEF_GAP,
  parameter int REP_W = DEF_REP_W
) (
  input  logic                clk,
  input  logic                reset,
  serial_pattern_tx_if.slave  bus
);

  localparam int BIT_W  = cnt_w(WIDTH);
  localparam int GAP_W  = cnt_w(GAP);
  localparam bit NO_GAP = (GAP == 0);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP == 0) ? 0 : GAP - 1);

  tx_state_t        state;
  logic [WIDTH-1:0] pat_q;
  logic [REP_W-1:0] rep_left;
  logic [BIT_W-1:0] bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             ready_q;
  logic             w_valid_q;
  logic             done_q;

  logic             accept;
  logic             last_bit;
  logic             more;
  logic             gap_last;
  logic             kill;
  logic             sh_load;
  logic             sh_shift;
  logic             sh_msb;
  logic [WIDTH-1:0] sh_din;

  assign accept   = (state == ST_IDLE) && bus.start;
  assign last_bit = (state == ST_SHIFT) && (bit_cnt == BIT_LAST);
  assign more     = rep_left > REP_W'(1);
  assign gap_last = (state == ST_GAP) && (gap_cnt == GAP_LAST);
  assign kill     = bus.abort && ((state == ST_SHIFT) || (state == ST_GAP));

  // The shift register loads straight from the bus on accept, otherwise it
  // reloads from the latched copy so later bus changes cannot leak in.
  assign sh_din   = accept ? bus.pattern : pat_q;
  assign sh_load  = (accept && (bus.rep_cnt != '0)) ||
                    (!kill && ((last_bit && more && NO_GAP) || gap_last));
  assign sh_shift = (state == ST_SHIFT) && !kill && !last_bit;

  piso_shift_reg #(.WIDTH(WIDTH)) u_piso (
    .clk      (clk),
    .reset    (reset),
    .load     (sh_load),
    .shift_en (sh_shift),
    .din      (sh_din),
    .msb      (sh_msb)
  );

  // NOTE: all state and output flops use non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      pat_q     <= '0;
      rep_left  <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      ready_q   <= 1'b1;
      w_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            pat_q    <= bus.pattern;
            rep_left <= bus.rep_cnt;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            ready_q  <= 1'b0;
            if (bus.rep_cnt == '0) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              state     <= ST_SHIFT;
              w_valid_q <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (bus.abort) begin
            state     <= ST_IDLE;
            w_valid_q <= 1'b0;
            ready_q   <= 1'b1;
          end else if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (rep_left != '0) rep_left <= rep_left - REP_W'(1);
            if (!more) begin
              state     <= ST_DONE;
              done_q    <= 1'b1;
              w_valid_q <= 1'b0;
            end else if (!NO_GAP) begin
              state     <= ST_GAP;
              gap_cnt   <= '0;
              w_valid_q <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        ST_GAP: begin
          if (bus.abort) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
          end else if (gap_cnt == GAP_LAST) begin
            state     <= ST_SHIFT;
            gap_cnt   <= '0;
            w_valid_q <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          ready_q   <= 1'b1;
          w_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready   = ready_q;
  assign bus.w_valid = w_valid_q;
  assign bus.w       = sh_msb & w_valid_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: directed scenarios plus random traffic, all
// compared every cycle against a transaction-level expected-output queue.
module tb_serial_pattern_tx;

  localparam int WIDTH = 8;
  localparam int GAP   = 2;
  localparam int REP_W = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_pattern_tx_if #(.WIDTH(WIDTH), .REP_W(REP_W)) bus ();

  serial_pattern_tx #(.WIDTH(WIDTH), .GAP(GAP), .REP_W(REP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs per cycle: {ready, w_valid, w, done} plus whether the
  // cycle belongs to an abortable (bit or gap) phase.
  typedef struct packed {
    logic [3:0] outs;
    logic       active;
  } exp_t;

  localparam exp_t IDLE_E = '{outs: 4'b1000, active: 1'b0};

  exp_t q[$];
  exp_t cur = IDLE_E;

  function automatic void build(input logic [WIDTH-1:0] pat, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int b = WIDTH - 1; b >= 0; b--)
        q.push_back('{outs: {1'b0, 1'b1, pat[b], 1'b0}, active: 1'b1});
      if (r < reps - 1)
        for (int g = 0; g < GAP; g++)
          q.push_back('{outs: 4'b0000, active: 1'b1});
    end
    q.push_back('{outs: 4'b0001, active: 1'b0});
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      cur = IDLE_E;
    end else if (cur.active && bus.abort) begin
      q.delete();
      cur = IDLE_E;
    end else if (cur.outs[3] && bus.start) begin
      build(bus.pattern, int'(bus.rep_cnt));
      cur = q.pop_front();
    end else begin
      cur = (q.size() == 0) ? IDLE_E : q.pop_front();
    end
  end

  always @(negedge clk) begin
    if (!reset)
      check("cycle_outs", {bus.ready, bus.w_valid, bus.w, bus.done}, cur.outs);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [WIDTH-1:0] pat, input logic [REP_W-1:0] reps);
    int n = 0;
    while (!bus.ready && n < 200) begin
      tick();
      n++;
    end
    if (!bus.ready) check("ready_timeout", 32'(bus.ready), 32'd1);
    bus.start   = 1'b1;
    bus.pattern = pat;
    bus.rep_cnt = reps;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic collect8(output logic [7:0] bits);
    bits = '0;
    for (int i = 0; i < 8; i++) begin
      check("collect_valid", 32'(bus.w_valid), 32'd1);
      bits = {bits[6:0], bus.w};
      tick();
    end
  endtask

  initial begin
    logic [7:0] bits;
    logic [7:0] exp_bits;
    int         cnt;

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.pattern = '0;
    bus.rep_cnt = '0;
    bus.abort   = 1'b0;
    #1;
    check("reset_outs", {bus.ready, bus.w_valid, bus.w, bus.done}, 4'b1000);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Single repeat, bit-exact
    exp_bits = 8'b1011_0010;
    send(8'b1011_0010, 4'd1);
    for (int i = 0; i < 8; i++) begin
      check("t1_valid", 32'(bus.w_valid), 32'd1);
      check("t1_bit", 32'(bus.w), 32'(exp_bits[7 - i]));
      tick();
    end
    check("t1_done", 32'(bus.done), 32'd1);
    check("t1_ready_in_done", 32'(bus.ready), 32'd0);
    tick();
    check("t1_ready_after", 32'(bus.ready), 32'd1);

    // Three repeats with gap: done 29 cycles after accept
    send(8'hA5, 4'd3);
    cnt = 1;
    while (!bus.done && cnt < 100) begin
      tick();
      cnt++;
    end
    check("t2_done_cycle", 32'(cnt), 32'd29);
    tick();

    // Zero repeats
    send(8'h3C, 4'd0);
    check("t3_done", 32'(bus.done), 32'd1);
    check("t3_valid", 32'(bus.w_valid), 32'd0);
    tick();
    check("t3_ready", 32'(bus.ready), 32'd1);

    // Busy handshake: bus changes during transmission are ignored
    send(8'h0F, 4'd1);
    bus.start   = 1'b1;
    bus.pattern = 8'hFF;
    bus.rep_cnt = 4'd5;
    collect8(bits);
    check("t4_bits", 32'(bits), 32'h0F);
    bus.start = 1'b0;
    check("t4_done", 32'(bus.done), 32'd1);
    tick();
    send(8'hFF, 4'd1);
    collect8(bits);
    check("t4_ones", 32'(bits), 32'hFF);
    tick();

    // Abort on the 4th bit
    send(8'h96, 4'd2);
    tick();
    tick();
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t5_valid", 32'(bus.w_valid), 32'd0);
    check("t5_ready", 32'(bus.ready), 32'd1);
    for (int i = 0; i < 30; i++) begin
      if (bus.done) check("t5_no_done", 32'(bus.done), 32'd0);
      tick();
    end
    send(8'hC3, 4'd1);
    collect8(bits);
    check("t5_restart", 32'(bits), 32'hC3);
    tick();

    // Asynchronous reset mid-shift
    send(8'hFF, 4'd2);
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check("t6_async", {bus.ready, bus.w_valid, bus.w, bus.done}, 4'b1000);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t6_idle", {bus.ready, bus.w_valid, bus.w, bus.done}, 4'b1000);
      tick();
    end

    // Random traffic, checked by the per-cycle compare
    for (int i = 0; i < 3000; i++) begin
      bus.start   = ($urandom_range(0, 3) == 0);
      bus.pattern = WIDTH'($urandom);
      bus.rep_cnt = REP_W'($urandom_range(0, 3));
      bus.abort   = ($urandom_range(0, 40) == 0);
      tick();
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int i = 0; i < 100; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
